prach_decim: RTL
================

Name: prach_decim

Overview:
- Per-channel integrate-and-dump decimator directly downstream of the PRACH mixer.
- Consumes the mixer's 3-lane, 8-channel TDM complex stream and averages every DECIM consecutive samples of each TDM channel into one output sample.
- Keeps an independent accumulator and phase counter per (lane, channel).
- Output keeps the same lane/TDM format, so later filter stages can reuse the same interface.

Parameters:
- DECIM, 4, decimation factor; power of two, 1..16.
- NUM_CHN, 8, number of TDM channels; din_chn values >= NUM_CHN are ignored.

Ports:
- clk  input  1  processing clock.
- rst_n  input  1  synchronous active-low reset.
- din_dr  input  16x3  real part per lane, signed two's complement.
- din_di  input  16x3  imaginary part per lane, signed.
- din_dv  input  1  input sample valid, shared by all lanes.
- din_chn  input  8  TDM channel index of the input sample.
- sync_in  input  1  single-cycle frame-boundary pulse.
- dout_dr  output  16x3  decimated real part per lane, signed.
- dout_di  output  16x3  decimated imaginary part per lane, signed.
- dout_dv  output  1  output sample valid.
- dout_chn  output  8  TDM channel index of the output sample.
- sync_out  output  1  sync_in delayed by 2 cycles.

Behaviour:
- Clocking/reset: single clock clk. rst_n is synchronous and active-low.
- While rst_n=0: all outputs are 0, all accumulators are 0, all phase counters are 0.
- State per channel c: phase[c] (log2(DECIM) bits, shared by all lanes); acc_r[i][c] and acc_i[i][c] (16+log2(DECIM) bits, signed).
- Accept condition: sample accepted when din_dv=1 and din_chn<NUM_CHN. Otherwise no state change and no output.
- Accepted sample, per lane and component:
  - sum = (phase[c]==0 ? 0 : acc[c]) + sign-extended din.
  - acc[c] <= sum.
  - phase[c] <= (phase[c]==DECIM-1) ? 0 : phase[c]+1.
- Dump: when the accepted sample has phase[c]==DECIM-1, the output is round-half-up(sum / DECIM) = (sum + DECIM/2) >>> log2(DECIM), truncated to 16 bits.
  - This result always fits in 16 bits: |avg| <= 32768, and the positive peak maps to 32767. No saturation logic is required.
- Latency is exactly 2 cycles from input cycle to dout_dv.
  - Stage 1: state update plus registered sum/dump flag/channel.
  - Stage 2: rounding and output registers.
- dout_dv is high for 1 cycle per dump. dout_chn is the channel of the dumped sample.
- dout_dr/dout_di hold their last value when dout_dv=0.
- Back-to-back accepted samples on the same channel must accumulate correctly. The state update is single-cycle, so no read-after-write hazard is allowed.
- sync_in handling:
  - On a cycle with sync_in=1, every phase[c] is treated as 0 before the cycle's sample is applied.
  - A sample arriving in the same cycle starts a fresh accumulation at phase 0, and its channel's phase becomes 1 (or it dumps immediately when DECIM=1).
  - Partial accumulations on all channels are discarded without output.
  - sync_out = sync_in delayed 2 cycles, independent of din_dv.
- DECIM=1: every accepted sample passes through unchanged with 2-cycle latency.
- Reset asserted mid-accumulation clears all state. The first accepted sample after release is phase 0 for its channel.
- Lanes always share dv/chn/phase. dout_dv, dout_chn and sync_out are common to all lanes.

Test Plan:
- DECIM=4, chn 0 only, dr lane0 = 10,20,30,41 on consecutive valid cycles -> one dout_dv, 2 cycles after the 4th input, dout_dr[0]=25 (101+2=103>>2), dout_chn=0.
- DECIM=4, interleave chn 0..7 round-robin, lane0 dr = chn*100 + k, k=0..3 -> 8 outputs in order chn 0..7, dout_dr[0] = chn*100+2, no cross-channel leakage.
- DECIM=4, chn 3 fed 32767 x4 then -32768 x4 on all lanes/components -> outputs 32767 then -32768, no wrap.
- DECIM=4: 2 samples on chn 5, then sync_in pulse with no dv, then 4 samples of value 8 -> single output 8, partial sum discarded; sync_out pulses exactly 2 cycles after sync_in.
- Inputs with din_chn=9 interleaved with valid chn 1 samples -> chn 9 samples produce no output and do not change the chn 1 result; din_dv=0 cycles stall without effect.
- rst_n low for 1 cycle after 3 samples on chn 2, then 4 samples of value -6 -> all outputs 0 during reset, then one output -6 (-24+2>>2=-6); DECIM=1 build: each input echoed at +2 cycles.

Source files
------------

// File: rtl/prach_decim_if.sv
// Lane/TDM complex sample stream shared by the PRACH mixer and decimation stages.
// Three lanes of 16-bit signed I/Q with a common valid, channel tag and frame sync.
interface prach_decim_if;
  logic [2:0][15:0] dr;
  logic [2:0][15:0] di;
  logic             dv;
  logic [7:0]       chn;
  logic             sync;

  modport master (output dr, di, dv, chn, sync);
  modport slave  (input  dr, di, dv, chn, sync);
endinterface

// File: rtl/prach_decim.sv
// Per-channel integrate-and-dump decimator: averages every DECIM samples of each TDM
// channel with round-half-up, keeping the 3-lane TDM stream format. Two-cycle latency.
module prach_decim #(
  parameter int unsigned DECIM   = 4,
  parameter int unsigned NUM_CHN = 8
) (
  input logic           clk,
  input logic           rst_n,
  prach_decim_if.slave  din,
  prach_decim_if.master dout
);
  localparam int unsigned Lanes = 3;
  localparam int unsigned Log2D = $clog2(DECIM);
  localparam int unsigned Pw    = (Log2D > 0) ? Log2D : 1;
  localparam int unsigned Aw    = 16 + Log2D;
  localparam int unsigned Cw    = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
  localparam logic [Pw-1:0]        PhLast = Pw'(DECIM - 1);
  localparam logic signed [Aw-1:0] Half   = Aw'(DECIM / 2);
  localparam logic [8:0]           ChnLim = 9'(NUM_CHN);

  typedef logic signed [Aw-1:0] acc_t;

  logic [Pw-1:0] phase_q [NUM_CHN];
  logic [Pw-1:0] phase_d [NUM_CHN];
  acc_t          acc_r_q [Lanes][NUM_CHN];
  acc_t          acc_r_d [Lanes][NUM_CHN];
  acc_t          acc_i_q [Lanes][NUM_CHN];
  acc_t          acc_i_d [Lanes][NUM_CHN];

  acc_t          sum_r [Lanes];
  acc_t          sum_i [Lanes];
  logic          accept;
  logic          dump;
  logic [Cw-1:0] ch;
  logic [Pw-1:0] cur_phase;

  acc_t          s1_sum_r [Lanes];
  acc_t          s1_sum_i [Lanes];
  logic          s1_dump;
  logic [7:0]    s1_chn;
  logic          s1_sync;

  assign accept = din.dv && ({1'b0, din.chn} < ChnLim);
  assign ch     = din.chn[Cw-1:0];

  // A sync pulse restarts every channel before this cycle's sample is folded in, so the
  // accumulator of a phase-0 sample is simply ignored rather than cleared.
  always_comb begin
    phase_d   = phase_q;
    acc_r_d   = acc_r_q;
    acc_i_d   = acc_i_q;
    dump      = 1'b0;
    cur_phase = din.sync ? '0 : phase_q[ch];
    for (int l = 0; l < Lanes; l++) begin
      sum_r[l] = '0;
      sum_i[l] = '0;
    end
    if (din.sync) begin
      for (int c = 0; c < NUM_CHN; c++) phase_d[c] = '0;
    end
    if (accept) begin
      for (int l = 0; l < Lanes; l++) begin
        sum_r[l] = ((cur_phase == '0) ? acc_t'(0) : acc_r_q[l][ch]) + acc_t'($signed(din.dr[l]));
        sum_i[l] = ((cur_phase == '0) ? acc_t'(0) : acc_i_q[l][ch]) + acc_t'($signed(din.di[l]));
        acc_r_d[l][ch] = sum_r[l];
        acc_i_d[l][ch] = sum_i[l];
      end
      phase_d[ch] = (cur_phase == PhLast) ? '0 : cur_phase + Pw'(1);
      dump        = (cur_phase == PhLast);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHN; c++) begin
        phase_q[c] <= '0;
        for (int l = 0; l < Lanes; l++) begin
          acc_r_q[l][c] <= '0;
          acc_i_q[l][c] <= '0;
        end
      end
      for (int l = 0; l < Lanes; l++) begin
        s1_sum_r[l] <= '0;
        s1_sum_i[l] <= '0;
      end
      s1_dump <= 1'b0;
      s1_chn  <= '0;
      s1_sync <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      acc_r_q  <= acc_r_d;
      acc_i_q  <= acc_i_d;
      s1_sum_r <= sum_r;
      s1_sum_i <= sum_i;
      s1_dump  <= dump;
      s1_chn   <= din.chn;
      s1_sync  <= din.sync;
    end
  end

  // Rounded average always fits 16 bits, so plain truncation is exact.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout.dv   <= 1'b0;
      dout.sync <= 1'b0;
      dout.chn  <= '0;
      dout.dr   <= '0;
      dout.di   <= '0;
    end else begin
      dout.dv   <= s1_dump;
      dout.sync <= s1_sync;
      if (s1_dump) begin
        dout.chn <= s1_chn;
        for (int l = 0; l < Lanes; l++) begin
          dout.dr[l] <= 16'((s1_sum_r[l] + Half) >>> Log2D);
          dout.di[l] <= 16'((s1_sum_i[l] + Half) >>> Log2D);
        end
      end
    end
  end
endmodule
